// File: rtl/wm8731_pkg.sv
// Shared types and widths for the WM8731 SPI init sequencer.
// Imported by the interface, the phase counter and the top.
package wm8731_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;
  localparam int BIT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    SCLK_LO,
    SCLK_HI,
    HOLD,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/wm8731_spi_init_if.sv
// ROM-side and codec-side signals of the init sequencer.
// master = sequencer, slave = ROM/codec/control side.
interface wm8731_spi_init_if;
  import wm8731_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic              spi_csb;
  logic              spi_sclk;
  logic              spi_sdin;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  rom_data,
    output rom_addr,
    output spi_csb,
    output spi_sclk,
    output spi_sdin,
    output busy,
    output done
  );

  modport slave (
    output start,
    output rom_data,
    input  rom_addr,
    input  spi_csb,
    input  spi_sclk,
    input  spi_sdin,
    input  busy,
    input  done
  );

endinterface

// File: rtl/spi_phase_cnt.sv
// Shared phase down-counter; expire is high while the count sits at zero.
// A load of N-1 therefore gives a phase of exactly N cycles.
module spi_phase_cnt
  import wm8731_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/wm8731_spi_init.sv
// Walks the init ROM and shifts each word to the WM8731 over 3-wire SPI.
// Words go out MSB first; the codec latches on the CSB rising edge.
module wm8731_spi_init
  import wm8731_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int ROM_DEPTH   = 11,
  parameter int START_DELAY = 1000,
  parameter int GAP_CYCLES  = 8,
  parameter int AUTO_START  = 1
) (
  input  logic              clk,
  input  logic              rst,
  wm8731_spi_init_if.master bus
);

  localparam logic [CNT_W-1:0] DIV_L =
    CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] START_L =
    CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] GAP_L =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(ROM_DEPTH - 1);
  localparam state_e RST_ST =
    (AUTO_START != 0) ? WAIT : IDLE;
  localparam logic [CNT_W-1:0] CNT_RST =
    (AUTO_START != 0) ? START_L : '0;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-2:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              csb_q, csb_d;
  logic              sclk_q, sclk_d;
  logic              sdin_q, sdin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ld;
  logic [CNT_W-1:0]  ld_val;
  logic              expire;

  spi_phase_cnt #(
    .RST_VAL (CNT_RST)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .expire   (expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    csb_d   = csb_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = WAIT;
          addr_d  = '0;
        end
      end
      WAIT: begin
        if (expire) state_d = LOAD;
      end
      LOAD: begin
        shreg_d = bus.rom_data[WORD_W-2:0];
        sdin_d  = bus.rom_data[WORD_W-1];
        csb_d   = 1'b0;
        sclk_d  = 1'b0;
        bit_d   = BIT_W'(WORD_W - 1);
        state_d = SCLK_LO;
      end
      SCLK_LO: begin
        if (expire) begin
          sclk_d  = 1'b1;
          state_d = SCLK_HI;
        end
      end
      SCLK_HI: begin
        if (expire) begin
          sclk_d = 1'b0;
          if (bit_q != '0) begin
            sdin_d  = shreg_q[WORD_W-2];
            shreg_d = {shreg_q[WORD_W-3:0], 1'b0};
            bit_d   = bit_q - 1'b1;
            state_d = SCLK_LO;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (expire) begin
          csb_d   = 1'b1;
          sdin_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (expire) begin
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = !(state_d inside {IDLE, DONE});
    done_d = (state_d == DONE);

    // every state change restarts the phase timer for the new state
    ld = (state_d != state_q);
    unique case (state_d)
      WAIT:    ld_val = START_L;
      GAP:     ld_val = GAP_L;
      default: ld_val = DIV_L;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_ST;
      addr_q  <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdin_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.spi_csb  = csb_q;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_sdin = sdin_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
